// File: rtl/online_otf_if.sv
// Handshake bundle between a redundant-digit producer and the on-the-fly converter.
// The producer/consumer side uses master; the converter uses slave.
interface online_otf_if #(
    parameter int NDIG = 13
) ();
    logic [2*NDIG-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic [NDIG:0]     dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_err;

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, dout_err
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, dout_err
    );
endinterface

// File: rtl/online_otf_converter.sv
// Serial MSD-first conversion of a radix-2 signed-digit word to two's complement
// using the Q/QM on-the-fly scheme, one digit per clock.
module online_otf_converter #(
    parameter int NDIG = 13
) (
    input  logic       clk,
    input  logic       rst,
    online_otf_if.slave bus
);
    localparam int W  = NDIG + 1;
    localparam int CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The 11 code is not a legal digit; it converts as zero but is flagged.
    function automatic logic is_bad_digit(input logic [1:0] d);
        return (d == 2'b11);
    endfunction

    logic [1:0]        state_r;
    logic [CW-1:0]     cnt_r;
    logic [2*NDIG-1:0] sr_r;
    logic [W-1:0]      q_r;
    logic [W-1:0]      qm_r;
    logic              err_r;
    logic              din_ready_r;
    logic              dout_valid_r;

    logic [1:0]        digit_s;
    logic [W-1:0]      q_next_s;
    logic [W-1:0]      qm_next_s;
    logic              bad_s;

    // Next Q/QM for the digit at the top of the shift register (QM tracks Q-1).
    always_comb begin
        digit_s   = sr_r[2*NDIG-1 -: 2];
        bad_s     = is_bad_digit(digit_s);
        q_next_s  = {q_r[W-2:0], 1'b0};
        qm_next_s = {qm_r[W-2:0], 1'b1};
        case (digit_s)
            2'b10: begin
                q_next_s  = {q_r[W-2:0], 1'b1};
                qm_next_s = {q_r[W-2:0], 1'b0};
            end
            2'b01: begin
                q_next_s  = {qm_r[W-2:0], 1'b1};
                qm_next_s = {qm_r[W-2:0], 1'b0};
            end
            default: begin
                q_next_s  = {q_r[W-2:0], 1'b0};
                qm_next_s = {qm_r[W-2:0], 1'b1};
            end
        endcase
    end

    // Control FSM, digit shift register, conversion registers and output flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            sr_r         <= '0;
            q_r          <= '0;
            qm_r         <= '1;
            err_r        <= 1'b0;
            din_ready_r  <= 1'b1;
            dout_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.din_valid) begin
                        sr_r        <= bus.din;
                        q_r         <= '0;
                        qm_r        <= '1;
                        cnt_r       <= '0;
                        err_r       <= 1'b0;
                        din_ready_r <= 1'b0;
                        state_r     <= CONV;
                    end
                end
                CONV: begin
                    sr_r  <= {sr_r[2*NDIG-3:0], 2'b00};
                    q_r   <= q_next_s;
                    qm_r  <= qm_next_s;
                    err_r <= err_r | bad_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST) begin
                        dout_valid_r <= 1'b1;
                        state_r      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.dout_ready) begin
                        dout_valid_r <= 1'b0;
                        din_ready_r  <= 1'b1;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    din_ready_r  <= 1'b1;
                    dout_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.din_ready  = din_ready_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.dout       = q_r;
    assign bus.dout_err   = err_r;
endmodule
